// File: rtl/if_id_hazard_stage_pkg.sv
// if_id_hazard_stage_pkg: shared pipeline constants and register-field helpers
package if_id_hazard_stage_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int CNT_W = 16;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;
  function automatic logic [4:0] rs1_of(input logic [31:0] i);
    return i[RS1_MSB:RS1_LSB];
  endfunction
  function automatic logic [4:0] rs2_of(input logic [31:0] i);
    return i[RS2_MSB:RS2_LSB];
  endfunction
endpackage

// File: rtl/if_id_hazard_stage_hazard_detect.sv
// hazard_detect: combinational load-use compare of decode sources against the ID/EX load destination
module hazard_detect (
  input  logic       valid,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);
  assign hazard = mem_read & valid & (ex_rd != 5'd0) & ((ex_rd == rs1) | (ex_rd == rs2));
endmodule

// File: rtl/if_id_hazard_stage.sv
// if_id_hazard_stage: IF/ID pipeline register with load-use stall, branch flush and event counters
module if_id_hazard_stage #(
  parameter logic [31:0] NOP_INSTR = if_id_hazard_stage_pkg::NOP_INSTR,
  parameter int          CNT_W     = if_id_hazard_stage_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      PC_addr,
  input  logic [31:0]      instruction,
  input  logic             Branch_taken,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_rd,
  output logic [63:0]      PC_addr_store,
  output logic [31:0]      instruction_store,
  output logic             valid_store,
  output logic             PC_Write,
  output logic             ID_EX_Flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  import if_id_hazard_stage_pkg::*;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic hazard, stall;
  hazard_detect u_hazard_detect (
    .valid(valid_q),
    .rs1(rs1_of(ins_q)),
    .rs2(rs2_of(ins_q)),
    .mem_read(ID_EX_MemRead),
    .ex_rd(ID_EX_rd),
    .hazard(hazard)
  );
  always_comb begin
    stall = hazard & ~Branch_taken;
    PC_Write = ~stall;
    ID_EX_Flush = Branch_taken | hazard;
    pc_d = Branch_taken ? 64'd0 : stall ? pc_q : PC_addr;
    ins_d = Branch_taken ? NOP_INSTR : stall ? ins_q : instruction;
    valid_d = ~Branch_taken & (stall ? valid_q : 1'b1);
    stall_d = stall_q + CNT_W'(stall & ~&stall_q);
    flush_d = flush_q + CNT_W'(Branch_taken & ~&flush_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
      ins_q <= NOP_INSTR;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      pc_q <= pc_d;
      ins_q <= ins_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign PC_addr_store = pc_q;
  assign instruction_store = ins_q;
  assign valid_store = valid_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;
endmodule

// File: tb/tb_if_id_hazard_stage.sv
// tb_if_id_hazard_stage: directed and randomized checks of the IF/ID stage against a behavioural model
module tb_if_id_hazard_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD = 32'h0072_8333;
  localparam logic [31:0] I0 = 32'h0000_0093;
  localparam logic [31:0] I1 = 32'h0000_0113;
  localparam logic [31:0] I2 = 32'h0000_0193;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [63:0] PC_addr = '0;
  logic [31:0] instruction = '0;
  logic Branch_taken = 1'b0;
  logic ID_EX_MemRead = 1'b0;
  logic [4:0] ID_EX_rd = '0;
  logic [63:0] PC_addr_store, s_pc;
  logic [31:0] instruction_store, s_ins;
  logic valid_store, PC_Write, ID_EX_Flush, s_valid, s_pcw, s_flush;
  logic [15:0] stall_count, flush_count;
  logic [2:0] s_stall_count, s_flush_count;
  int tests = 0;
  int fails = 0;
  bit check_en = 0;
  logic [63:0] m_pc = '0;
  logic [31:0] m_ins = NOP;
  bit m_v = 0;
  longint m_st = 0;
  longint m_fl = 0;

  always #5 clk = ~clk;

  if_id_hazard_stage dut (
    .clk(clk), .reset(reset), .PC_addr(PC_addr), .instruction(instruction),
    .Branch_taken(Branch_taken), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .PC_addr_store(PC_addr_store), .instruction_store(instruction_store), .valid_store(valid_store),
    .PC_Write(PC_Write), .ID_EX_Flush(ID_EX_Flush), .stall_count(stall_count), .flush_count(flush_count)
  );

  if_id_hazard_stage #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .PC_addr(PC_addr), .instruction(instruction),
    .Branch_taken(Branch_taken), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
    .PC_addr_store(s_pc), .instruction_store(s_ins), .valid_store(s_valid),
    .PC_Write(s_pcw), .ID_EX_Flush(s_flush), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  function automatic bit m_hz();
    logic [4:0] a, b;
    a = m_ins[19:15];
    b = m_ins[24:20];
    return ID_EX_MemRead && m_v && ID_EX_rd != 0 && (ID_EX_rd == a || ID_EX_rd == b);
  endfunction

  function automatic longint sat(longint n, int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return n > mx ? mx : n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = '0; m_ins = NOP; m_v = 0; m_st = 0; m_fl = 0;
    end else if (Branch_taken) begin
      m_pc = '0; m_ins = NOP; m_v = 0; m_fl++;
    end else if (m_hz()) begin
      m_st++;
    end else begin
      m_pc = PC_addr; m_ins = instruction; m_v = 1;
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_pc", PC_addr_store, m_pc);
      chk("m_ins", {32'd0, instruction_store}, {32'd0, m_ins});
      chk("m_valid", {63'd0, valid_store}, {63'd0, m_v});
      chk("m_pcw", {63'd0, PC_Write}, {63'd0, !(m_hz() && !Branch_taken)});
      chk("m_flush", {63'd0, ID_EX_Flush}, {63'd0, Branch_taken || m_hz()});
      chk("m_stall_cnt", {48'd0, stall_count}, 64'(sat(m_st, 16)));
      chk("m_flush_cnt", {48'd0, flush_count}, 64'(sat(m_fl, 16)));
      chk("m_sat_stall_cnt", {61'd0, s_stall_count}, 64'(sat(m_st, 3)));
      chk("m_sat_flush_cnt", {61'd0, s_flush_count}, 64'(sat(m_fl, 3)));
      chk("m_sat_pc", s_pc, m_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [63:0] pc, logic [31:0] ins, logic mr, logic [4:0] rd, logic bt);
    PC_addr = pc; instruction = ins; ID_EX_MemRead = mr; ID_EX_rd = rd; Branch_taken = bt;
  endtask

  initial begin
    bit prev_stall;
    reset = 1'b1;
    Branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_en = 1;
    chk("rst_pc", PC_addr_store, 64'd0);
    chk("rst_ins", {32'd0, instruction_store}, {32'd0, NOP});
    chk("rst_valid", {63'd0, valid_store}, 64'd0);
    chk("rst_cnt", {32'd0, stall_count, flush_count}, 64'd0);
    chk("rst_pcw", {63'd0, PC_Write}, 64'd1);
    chk("rst_flush", {63'd0, ID_EX_Flush}, 64'd1);
    reset = 1'b0;
    drv(64'h0, I0, 0, 0, 0);
    step();
    chk("f0_pc", PC_addr_store, 64'h0);
    chk("f0_ins", {32'd0, instruction_store}, {32'd0, I0});
    chk("f0_valid", {63'd0, valid_store}, 64'd1);
    drv(64'h4, I1, 0, 0, 0);
    step();
    chk("f1_pc", PC_addr_store, 64'h4);
    chk("f1_ins", {32'd0, instruction_store}, {32'd0, I1});
    drv(64'h8, I2, 0, 0, 0);
    #1 chk("f2_pcw", {63'd0, PC_Write}, 64'd1);
    step();
    chk("f2_pc", PC_addr_store, 64'h8);
    chk("f2_valid", {63'd0, valid_store}, 64'd1);
    drv(64'hC, ADD, 0, 0, 0);
    step();
    drv(64'h10, I1, 1, 5, 0);
    #1 chk("lu_pcw", {63'd0, PC_Write}, 64'd0);
    chk("lu_flush", {63'd0, ID_EX_Flush}, 64'd1);
    step();
    chk("lu_hold_pc", PC_addr_store, 64'hC);
    chk("lu_hold_ins", {32'd0, instruction_store}, {32'd0, ADD});
    chk("lu_stall_cnt", {48'd0, stall_count}, 64'd1);
    drv(64'h10, I1, 0, 5, 0);
    #1 chk("lu_end_pcw", {63'd0, PC_Write}, 64'd1);
    step();
    chk("lu_resume_pc", PC_addr_store, 64'h10);
    drv(64'h14, ADD, 0, 0, 0);
    step();
    drv(64'h18, I0, 1, 0, 0);
    #1 chk("rd0_pcw", {63'd0, PC_Write}, 64'd1);
    chk("rd0_flush", {63'd0, ID_EX_Flush}, 64'd0);
    step();
    chk("rd0_pc", PC_addr_store, 64'h18);
    chk("rd0_stall_cnt", {48'd0, stall_count}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drv(64'h20, ADD, 0, 0, 0);
    step();
    drv(64'h24, I0, 1, 7, 1);
    #1 chk("bh_pcw", {63'd0, PC_Write}, 64'd1);
    chk("bh_flush", {63'd0, ID_EX_Flush}, 64'd1);
    step();
    chk("bh_ins", {32'd0, instruction_store}, 64'h13);
    chk("bh_valid", {63'd0, valid_store}, 64'd0);
    chk("bh_pc", PC_addr_store, 64'd0);
    chk("bh_flush_cnt", {48'd0, flush_count}, 64'd1);
    chk("bh_stall_cnt", {48'd0, stall_count}, 64'd0);
    drv(64'h30, ADD, 0, 0, 0);
    step();
    drv(64'h34, I0, 1, 5, 0);
    #1 chk("mr_pcw", {63'd0, PC_Write}, 64'd0);
    #2 reset = 1'b1;
    #1 chk("mr_pc", PC_addr_store, 64'd0);
    chk("mr_ins", {32'd0, instruction_store}, 64'h13);
    chk("mr_valid", {63'd0, valid_store}, 64'd0);
    chk("mr_cnt", {32'd0, stall_count, flush_count}, 64'd0);
    chk("mr_pcw_rst", {63'd0, PC_Write}, 64'd1);
    #1 reset = 1'b0;
    drv(64'h40, I1, 0, 0, 0);
    step();
    chk("mr_rel_pc", PC_addr_store, 64'h40);
    chk("mr_rel_ins", {32'd0, instruction_store}, {32'd0, I1});
    chk("mr_rel_valid", {63'd0, valid_store}, 64'd1);
    prev_stall = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      drv({$urandom, $urandom}, ins, prev_stall ? 1'b0 : 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
      reset = $urandom_range(0, 399) == 0;
      #1;
      prev_stall = m_hz() && !Branch_taken && !reset;
      step();
    end
    reset = 1'b0;
    step();
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
